// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging one transaction at a time onto a single-port synchronous SRAM.
// Supports FIXED/INCR bursts; WRAP/reserved bursts and oversize beats complete as INCR with SLVERR.
module axi_sram_slave #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  // read address channel
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address channel
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  // debug
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid never waits for ready, and ready here is only ever raised in the state that consumes it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_RESP = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;        // 0: read wins a tie, 1: write wins a tie
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic        fixed_q, fixed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        bvalid_q, bvalid_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        ar_grant;
  logic        aw_grant;
  logic        w_hs;
  logic        last_cnt;
  logic        wlast_bad;
  logic [31:0] step;
  logic [31:0] next_addr;
  logic        unused_ok;

  assign ar_grant  = (state_q == IDLE) & arvalid & (~awvalid | ~prio_q);
  assign aw_grant  = (state_q == IDLE) & awvalid & (~arvalid | prio_q);
  assign w_hs      = (state_q == WR_DATA) & wvalid;
  assign last_cnt  = (cnt_q == len_q);
  assign wlast_bad = (wlast != last_cnt);
  assign step      = (size_q > 3'd2) ? 32'd4 : (32'd1 << size_q);
  assign next_addr = fixed_q ? addr_q : addr_q + step;

  assign arready    = ar_grant;
  assign awready    = aw_grant;
  assign wready     = (state_q == WR_DATA);
  assign sram_en    = (state_q == RD_REQ) | w_hs;
  assign sram_wen   = w_hs ? wstrb : 4'b0000;
  assign sram_addr  = addr_q[ADDR_W+1:2];
  assign sram_wdata = wdata;

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rid       = rid_q;
  assign rresp     = rresp_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign dbg_state = state_q;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, addr_q};

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    fixed_d  = fixed_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;

    case (state_q)
      IDLE: begin
        if (ar_grant) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          fixed_d = (arburst == 2'b00);
          cnt_d   = 8'd0;
          err_d   = arburst[1] | (arsize > 3'd2);
          prio_d  = 1'b1;
          state_d = RD_REQ;
        end else if (aw_grant) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          fixed_d = (awburst == 2'b00);
          cnt_d   = 8'd0;
          err_d   = awburst[1] | (awsize > 3'd2);
          prio_d  = 1'b0;
          state_d = WR_DATA;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d  = sram_rdata;
        rvalid_d = 1'b1;
        rlast_d  = last_cnt;
        rid_d    = id_q;
        rresp_d  = err_q ? 2'b10 : 2'b00;
        state_d  = RD_RESP;
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr;
            cnt_d   = cnt_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        if (wvalid) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (wlast_bad) err_d = 1'b1;
          // An early wlast closes the burst; beats past len are never requested.
          if (wlast | last_cnt) begin
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q | wlast_bad) ? 2'b10 : 2'b00;
            state_d  = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 4'd0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      fixed_q  <= 1'b0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= 4'd0;
      rresp_q  <= 2'b00;
      bvalid_q <= 1'b0;
      bid_q    <= 4'd0;
      bresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      fixed_q  <= fixed_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: behavioural SRAM, channel driver tasks,
// read-data scoreboard and a single summary line.
module tb_axi_sram_slave;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        arid = '0;
  logic [31:0]       araddr = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [3:0]        awid = '0;
  logic [31:0]       awaddr = '0;
  logic [7:0]        awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awburst = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata = '0;
  logic [2:0]        dbg_state;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [31:0]       bd_data = '0;
  int                wr_cnt = 0;

  int                n_vec = 0;
  int                n_err = 0;
  logic [31:0]       exp_q[$];

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port SRAM with one-cycle read latency and a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      if (sram_wen == 4'b0000) sram_rdata <= mem[sram_addr];
    end
    if (sram_en && sram_wen != 4'b0000) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic ar_drive(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic aw_drive(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic ar_wait();
    int n = 0;
    #1;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("ar_handshake", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic aw_wait();
    int n = 0;
    #1;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("aw_handshake", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last,
                        input logic [31:0] exp_word);
    int n = 0;
    wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    #1;
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("w_ready", {31'd0, wready}, 32'd1);
    check("w_sram_en", {31'd0, sram_en}, 32'd1);
    check("w_sram_wen", {28'd0, sram_wen}, {28'd0, strb});
    check("w_sram_addr", {16'd0, sram_addr}, exp_word);
    check("w_sram_wdata", sram_wdata, d);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Called on the falling edge right after the AR handshake or the previous R beat.
  task automatic get_r(input logic [3:0] eid, input logic [1:0] eresp, input logic elast,
                       input int stall);
    int lat = 0;
    logic [31:0] held;
    logic [31:0] exp;
    rready = 1'b0;
    do begin @(negedge clk); lat++; end while (rvalid !== 1'b1 && lat < 50);
    check("r_latency", lat, 32'd2);
    held = rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("r_stall_valid", {31'd0, rvalid}, 32'd1);
      check("r_stall_data", rdata, held);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check("r_data", rdata, exp);
    check("r_id", {28'd0, rid}, {28'd0, eid});
    check("r_resp", {30'd0, rresp}, {30'd0, eresp});
    check("r_last", {31'd0, rlast}, {31'd0, elast});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] eid, input logic [1:0] eresp);
    int n = 0;
    bready = 1'b0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("b_valid", {31'd0, bvalid}, 32'd1);
    check("b_id", {28'd0, bid}, {28'd0, eid});
    check("b_resp", {30'd0, bresp}, {30'd0, eresp});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done_valid", {31'd0, bvalid}, 32'd0);
    check("b_done_state", {29'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int wr_base;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rlast", {31'd0, rlast}, 32'd0);
    check("rst_sram_en", {31'd0, sram_en}, 32'd0);
    check("rst_sram_wen", {28'd0, sram_wen}, 32'd0);
    check("rst_ids", {24'd0, rid, bid}, 32'd0);
    check("rst_resps", {28'd0, rresp, bresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);

    preload(16'h0010, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) preload(16'h0040 + 16'(i), 32'hA000_0000 + 32'(i));
    preload(16'h0002, 32'h1122_3344);

    // Tie straight after reset: read wins; single read of word 0x10.
    @(negedge clk);
    ar_drive(4'd3, 32'h0000_0040, 8'd0, 3'd2, 2'b01);
    aw_drive(4'd6, 32'h0000_0020, 8'd1, 3'd2, 2'b00);
    #1;
    check("tie1_arready", {31'd0, arready}, 32'd1);
    check("tie1_awready", {31'd0, awready}, 32'd0);
    ar_wait();
    check("rdreq_sram_en", {31'd0, sram_en}, 32'd1);
    check("rdreq_sram_wen", {28'd0, sram_wen}, 32'd0);
    check("rdreq_sram_addr", {16'd0, sram_addr}, 32'h10);
    check("busy_awready", {31'd0, awready}, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    get_r(4'd3, 2'b00, 1'b1, 0);

    // Second tie: write wins; FIXED 2-beat write lands twice on word 8.
    ar_drive(4'd7, 32'h0000_0100, 8'd3, 3'd2, 2'b01);
    #1;
    check("tie2_awready", {31'd0, awready}, 32'd1);
    check("tie2_arready", {31'd0, arready}, 32'd0);
    aw_wait();
    check("busy_arready", {31'd0, arready}, 32'd0);
    send_w(32'h0101_0101, 4'hF, 1'b0, 32'h8);
    send_w(32'h0202_0202, 4'hF, 1'b1, 32'h8);
    get_b(4'd6, 2'b00);

    // Pending INCR read of words 0x40..0x43, beat 1 stalled two cycles.
    ar_wait();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
    get_r(4'd7, 2'b00, 1'b0, 0);
    get_r(4'd7, 2'b00, 1'b0, 2);
    get_r(4'd7, 2'b00, 1'b0, 0);
    get_r(4'd7, 2'b00, 1'b1, 0);

    ar_drive(4'd1, 32'h0000_0020, 8'd0, 3'd2, 2'b01);
    ar_wait();
    exp_q.push_back(32'h0202_0202);
    get_r(4'd1, 2'b00, 1'b1, 0);

    // Byte-strobe write on word 2, then a zero-strobe beat that must not write.
    aw_drive(4'd5, 32'h0000_0008, 8'd0, 3'd2, 2'b01);
    aw_wait();
    send_w(32'hAABB_CCDD, 4'b0011, 1'b1, 32'h2);
    get_b(4'd5, 2'b00);
    wr_base = wr_cnt;
    aw_drive(4'd4, 32'h0000_0008, 8'd0, 3'd2, 2'b01);
    aw_wait();
    send_w(32'hFFFF_FFFF, 4'b0000, 1'b1, 32'h2);
    get_b(4'd4, 2'b00);
    check("zero_strb_writes", wr_cnt - wr_base, 32'd0);
    ar_drive(4'd2, 32'h0000_0008, 8'd0, 3'd2, 2'b01);
    ar_wait();
    exp_q.push_back(32'h1122_CCDD);
    get_r(4'd2, 2'b00, 1'b1, 0);

    // Early wlast on a 4-beat INCR write: two writes, SLVERR.
    wr_base = wr_cnt;
    aw_drive(4'd9, 32'h0000_0030, 8'd3, 3'd2, 2'b01);
    aw_wait();
    send_w(32'h0000_0055, 4'hF, 1'b0, 32'hC);
    send_w(32'h0000_0066, 4'hF, 1'b1, 32'hD);
    get_b(4'd9, 2'b10);
    check("early_wlast_writes", wr_cnt - wr_base, 32'd2);
    ar_drive(4'd8, 32'h0000_0030, 8'd1, 3'd2, 2'b01);
    ar_wait();
    exp_q.push_back(32'h0000_0055);
    exp_q.push_back(32'h0000_0066);
    get_r(4'd8, 2'b00, 1'b0, 0);
    get_r(4'd8, 2'b00, 1'b1, 0);

    // WRAP burst runs as INCR with SLVERR on every beat.
    ar_drive(4'd10, 32'h0000_0100, 8'd1, 3'd2, 2'b10);
    ar_wait();
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0001);
    get_r(4'd10, 2'b10, 1'b0, 0);
    get_r(4'd10, 2'b10, 1'b1, 0);

    // Reset while beat 1 of a 4-beat read waits in RD_RESP.
    ar_drive(4'd4, 32'h0000_0100, 8'd3, 3'd2, 2'b01);
    ar_wait();
    exp_q.push_back(32'hA000_0000);
    get_r(4'd4, 2'b00, 1'b0, 0);
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("pre_reset_rvalid", {31'd0, rvalid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("midrst_sram_en", {31'd0, sram_en}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    check("midrst_arready_lo", {31'd0, arready}, 32'd0);
    ar_drive(4'd2, 32'h0000_0104, 8'd0, 3'd2, 2'b01);
    #1;
    check("midrst_arready_hi", {31'd0, arready}, 32'd1);
    ar_wait();
    exp_q.push_back(32'hA000_0001);
    get_r(4'd2, 2'b00, 1'b1, 0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
